wb_arbiter: RTL and testbench

//  Write-back merge stage directly upstream of the 32x32 register file.
//  - Collects results from two producers into a small in-order FIFO:
//    A = ALU (single-cycle, priority) and B = load/mul unit (multi-cycle).
//  - Retires one entry per cycle onto the register-file write port (D, Wr, We).
//  - Provides two forwarding lookups so decode can read values that are still pending.

---
 rtl/wb_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Write-back merge stage feeding the register-file write port.
//   Results from the ALU (A, priority) and the load/mul unit (B) are merged
//   into a small in-order FIFO. One entry retires per cycle onto We/Wr/D.
//   Two combinational forwarding lookups expose pending values to decode.
//
// Ports
//   Clk, Clr               clock, synchronous active-high reset
//   A_Valid/A_Wr/A_D/A_Rdy ALU result handshake
//   B_Valid/B_Wr/B_D/B_Rdy load/mul result handshake
//   We, Wr, D              register-file write port (driven from FIFO head)
//   Ra, Rb                 forwarding lookup addresses
//   Fa_Hit/Fa_D, Fb_Hit/Fb_D  forwarding results (youngest pending match)
//   Count, Full, Empty     FIFO occupancy
//
// Handshake: a producer transfers when Valid and Rdy are both high at a rising
// edge of Clk; it holds Valid/Wr/D stable until Rdy. A_Rdy never looks at
// A_Valid; B_Rdy does, because an accepted A result consumes a slot first.
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic                       Clk,
  input  logic                       Clr,
  input  logic                       A_Valid,
  input  logic [AW-1:0]              A_Wr,
  input  logic [WIDTH-1:0]           A_D,
  output logic                       A_Rdy,
  input  logic                       B_Valid,
  input  logic [AW-1:0]              B_Wr,
  input  logic [WIDTH-1:0]           B_D,
  output logic                       B_Rdy,
  output logic                       We,
  output logic [AW-1:0]              Wr,
  output logic [WIDTH-1:0]           D,
  input  logic [AW-1:0]              Ra,
  input  logic [AW-1:0]              Rb,
  output logic                       Fa_Hit,
  output logic [WIDTH-1:0]           Fa_D,
  output logic                       Fb_Hit,
  output logic [WIDTH-1:0]           Fb_D,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Full,
  output logic                       Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [AW-1:0]    mem_wr [DEPTH];
  logic [WIDTH-1:0] mem_d  [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic             deq;
  logic [CW:0]      free;
  logic             enq_a;
  logic             enq_b;
  logic [PW-1:0]    tail_b;

  // Free space counts the slot being retired this cycle, so a full FIFO
  // still accepts one result per cycle.
  always_comb begin
    deq    = (count != '0);
    free   = DEPTH_W - {1'b0, count} + (CW + 1)'(deq);
    A_Rdy  = (free != '0);
    // Register 0 is never stored, so a Wr==0 transfer claims no slot.
    enq_a  = A_Valid & A_Rdy & (A_Wr != '0);
    B_Rdy  = (free >= ((CW + 1)'(enq_a) + (CW + 1)'(1)));
    enq_b  = B_Valid & B_Rdy & (B_Wr != '0);
    // A is older than B in the same cycle, so B lands behind it.
    tail_b = enq_a ? tail + PW'(1) : tail;
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_a) begin
        mem_wr[tail] <= A_Wr;
        mem_d[tail]  <= A_D;
      end
      if (enq_b) begin
        mem_wr[tail_b] <= B_Wr;
        mem_d[tail_b]  <= B_D;
      end
      tail  <= tail + PW'(enq_a) + PW'(enq_b);
      head  <= head + PW'(deq);
      count <= count + CW'(enq_a) + CW'(enq_b) - CW'(deq);
    end
  end

  // Retire port: head entry whenever the FIFO is non-empty.
  always_comb begin
    We = deq;
    Wr = deq ? mem_wr[head] : '0;
    D  = deq ? mem_d[head]  : '0;
  end

  assign Count = count;
  assign Full  = (count == CW'(DEPTH));
  assign Empty = (count == '0);

  // Forwarding: walk entries from oldest (head) to youngest so the last
  // match found is the youngest. Only the first 'count' slots are live.
  always_comb begin
    logic [PW-1:0] idx;
    Fa_Hit = 1'b0;
    Fa_D   = '0;
    Fb_Hit = 1'b0;
    Fb_D   = '0;
    idx    = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if ((Ra != '0) && (mem_wr[idx] == Ra)) begin
          Fa_Hit = 1'b1;
          Fa_D   = mem_d[idx];
        end
        if ((Rb != '0) && (mem_wr[idx] == Rb)) begin
          Fb_Hit = 1'b1;
          Fb_D   = mem_d[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  // ---------------- clock / reset ----------------
  logic        Clk;
  logic        Clr;
  logic        A_Valid;
  logic [4:0]  A_Wr;
  logic [31:0] A_D;
  logic        A_Rdy;
  logic        B_Valid;
  logic [4:0]  B_Wr;
  logic [31:0] B_D;
  logic        B_Rdy;
  logic        We;
  logic [4:0]  Wr;
  logic [31:0] D;
  logic [4:0]  Ra;
  logic [4:0]  Rb;
  logic        Fa_Hit;
  logic [31:0] Fa_D;
  logic        Fb_Hit;
  logic [31:0] Fb_D;
  logic [2:0]  Count;
  logic        Full;
  logic        Empty;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  wb_arbiter #(.DEPTH(4), .WIDTH(32), .AW(5)) dut (
    .Clk(Clk), .Clr(Clr),
    .A_Valid(A_Valid), .A_Wr(A_Wr), .A_D(A_D), .A_Rdy(A_Rdy),
    .B_Valid(B_Valid), .B_Wr(B_Wr), .B_D(B_D), .B_Rdy(B_Rdy),
    .We(We), .Wr(Wr), .D(D),
    .Ra(Ra), .Rb(Rb),
    .Fa_Hit(Fa_Hit), .Fa_D(Fa_D), .Fb_Hit(Fb_Hit), .Fb_D(Fb_D),
    .Count(Count), .Full(Full), .Empty(Empty)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];   // {wr, d} in expected retire order
  int m_count = 0;         // expected occupancy

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int unsigned chk, clr, av, awr, ad, bv, bwr, bd, ra, rb;
    int unsigned we, wr, d, a_rdy, b_rdy, fa_hit, fa_d, fb_hit, fb_d, cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic apply_vec(input vec_t v, input int n);
    @(negedge Clk);
    Clr     = v.clr[0];
    A_Valid = v.av[0];
    A_Wr    = 5'(v.awr);
    A_D     = v.ad;
    B_Valid = v.bv[0];
    B_Wr    = 5'(v.bwr);
    B_D     = v.bd;
    Ra      = 5'(v.ra);
    Rb      = 5'(v.rb);
    #1;
    if (v.chk != 0) begin
      check($sformatf("v%0d we", n),     32'(We),     v.we);
      check($sformatf("v%0d wr", n),     32'(Wr),     v.wr);
      check($sformatf("v%0d d", n),      D,           v.d);
      check($sformatf("v%0d a_rdy", n),  32'(A_Rdy),  v.a_rdy);
      check($sformatf("v%0d b_rdy", n),  32'(B_Rdy),  v.b_rdy);
      check($sformatf("v%0d fa_hit", n), 32'(Fa_Hit), v.fa_hit);
      check($sformatf("v%0d fa_d", n),   Fa_D,        v.fa_d);
      check($sformatf("v%0d fb_hit", n), 32'(Fb_Hit), v.fb_hit);
      check($sformatf("v%0d fb_d", n),   Fb_D,        v.fb_d);
      check($sformatf("v%0d count", n),  32'(Count),  v.cnt);
      check($sformatf("v%0d empty", n),  32'(Empty),  (v.cnt == 0) ? 1 : 0);
      check($sformatf("v%0d full", n),   32'(Full),   (v.cnt == 4) ? 1 : 0);
    end
  endtask

  // ---------------- driver with reference model ----------------
  // Drives one cycle, checks outputs against the occupancy model and the
  // expected queue, then advances the model for the coming edge.
  task automatic step(input logic clr, input logic av, input logic [4:0] awr,
                      input logic [31:0] ad, input logic bv, input logic [4:0] bwr,
                      input logic [31:0] bd, output logic a_acc, output logic b_acc);
    int  free;
    logic deq, ardy, needa, brdy;
    logic [36:0] head_e;
    @(negedge Clk);
    Clr = clr; A_Valid = av; A_Wr = awr; A_D = ad;
    B_Valid = bv; B_Wr = bwr; B_D = bd; Ra = '0; Rb = '0;
    #1;
    deq   = (m_count > 0);
    free  = 4 - m_count + (deq ? 1 : 0);
    ardy  = (free >= 1);
    needa = av && ardy && (awr != 0);
    brdy  = (free >= 1 + (needa ? 1 : 0));
    check("seq count", 32'(Count), 32'(m_count));
    check("seq full",  32'(Full),  32'(m_count == 4));
    check("seq a_rdy", 32'(A_Rdy), 32'(ardy));
    check("seq b_rdy", 32'(B_Rdy), 32'(brdy));
    check("seq we",    32'(We),    32'(deq));
    head_e = deq ? exp_q[0] : '0;
    check("seq wr", 32'(Wr), 32'(head_e[36:32]));
    check("seq d",  D,       head_e[31:0]);
    a_acc = av && ardy;
    b_acc = bv && brdy;
    if (clr) begin
      exp_q.delete();
    end else begin
      if (deq) void'(exp_q.pop_front());
      if (needa) exp_q.push_back({awr, ad});
      if (b_acc && (bwr != 0)) exp_q.push_back({bwr, bd});
    end
    m_count = exp_q.size();
  endtask

  // ---------------- test ----------------
  initial begin
    logic aa, ba;
    logic [4:0]  b_wr_cur;
    logic [31:0] b_d_cur;
    int b_idx;
    int drain;

    Clr = 1'b1; A_Valid = 0; A_Wr = 0; A_D = 0;
    B_Valid = 0; B_Wr = 0; B_D = 0; Ra = 0; Rb = 0;

    //            chk clr av awr ad           bv bwr bd   ra rb  we wr d            ar br fh fa_d         fbh fb_d cnt
    vecs.push_back('{0, 1, 0, 0, 0,           0, 0, 0,    0, 0,  0, 0, 0,           1, 1, 0, 0,           0, 0,   0});
    vecs.push_back('{1, 1, 0, 0, 0,           0, 0, 0,    0, 0,  0, 0, 0,           1, 1, 0, 0,           0, 0,   0});
    vecs.push_back('{1, 0, 1, 3, 'h11111111,  0, 0, 0,    3, 0,  0, 0, 0,           1, 1, 0, 0,           0, 0,   0});
    vecs.push_back('{1, 0, 0, 0, 0,           0, 0, 0,    3, 0,  1, 3, 'h11111111,  1, 1, 1, 'h11111111,  0, 0,   1});
    vecs.push_back('{1, 0, 0, 0, 0,           0, 0, 0,    3, 0,  0, 0, 0,           1, 1, 0, 0,           0, 0,   0});
    vecs.push_back('{1, 0, 1, 5, 'hA,         1, 5, 'hB,  5, 0,  0, 0, 0,           1, 1, 0, 0,           0, 0,   0});
    vecs.push_back('{1, 0, 0, 0, 0,           0, 0, 0,    5, 5,  1, 5, 'hA,         1, 1, 1, 'hB,         1, 'hB, 2});
    vecs.push_back('{1, 0, 0, 0, 0,           0, 0, 0,    5, 7,  1, 5, 'hB,         1, 1, 1, 'hB,         0, 0,   1});
    vecs.push_back('{1, 0, 0, 0, 0,           0, 0, 0,    5, 0,  0, 0, 0,           1, 1, 0, 0,           0, 0,   0});
    vecs.push_back('{1, 0, 1, 0, 'hDEAD,      0, 0, 0,    0, 0,  0, 0, 0,           1, 1, 0, 0,           0, 0,   0});
    vecs.push_back('{1, 0, 0, 0, 0,           0, 0, 0,    0, 0,  0, 0, 0,           1, 1, 0, 0,           0, 0,   0});

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Saturation: A and B valid every cycle; B holds its result until taken.
    m_count = 0;
    exp_q.delete();
    b_idx    = 0;
    b_wr_cur = 5'd20;
    b_d_cur  = 32'hB000_0000;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1, 5'((k % 15) + 1), 32'hA000_0000 + 32'(k),
           1'b1, b_wr_cur, b_d_cur, aa, ba);
      if (ba) begin
        b_idx++;
        b_wr_cur = 5'((b_idx % 15) + 16);
        b_d_cur  = 32'hB000_0000 + 32'(b_idx);
      end
    end
    drain = 0;
    while (m_count > 0 && drain < 10) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, ba);
      drain++;
    end
    check("drain empty", 32'(m_count), 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, ba);

    // Reset mid-operation with A_Valid high: pending entries are discarded.
    step(1'b0, 1'b1, 5'd1, 32'hC1, 1'b1, 5'd2, 32'hC2, aa, ba);
    step(1'b0, 1'b1, 5'd3, 32'hC3, 1'b1, 5'd4, 32'hC4, aa, ba);
    check("prefill count", 32'(m_count), 32'd3);
    step(1'b1, 1'b1, 5'd5, 32'hC5, 1'b0, 5'd0, 32'd0, aa, ba);
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, ba);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
